// File: rtl/act_pkg.sv
// Shared definitions for the activation dequantizing unpacker.
// The file holds the default geometry, the FSM encoding and the lane-index width helper.
package act_pkg;

    localparam int DATA_BITWIDTH = 8;
    localparam int ACC_BITWIDTH  = 32;
    localparam int FRAC_BITS     = 6;
    localparam int LANES         = 4;

    // IDLE: no word held. DRAIN: a word is held and its lanes are being emitted.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // A lane index needs at least one bit, even for a single-lane word.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANE_W = lane_w(LANES);

endpackage

// File: rtl/act_dequant.sv
// Expands one unsigned activation to accumulator fixed point.
// The value is zero-extended and then shifted left by FRAC_BITS.
// The result is exact: unsigned input means there is no sign, no rounding and no overflow.
module act_dequant
    import act_pkg::*;
#(
    parameter int DATA_BITWIDTH = act_pkg::DATA_BITWIDTH,
    parameter int ACC_BITWIDTH  = act_pkg::ACC_BITWIDTH,
    parameter int FRAC_BITS     = act_pkg::FRAC_BITS
) (
    input  logic [DATA_BITWIDTH-1:0] lane_data,
    output logic [ACC_BITWIDTH-1:0]  acc_data
);

    assign acc_data = ACC_BITWIDTH'(lane_data) << FRAC_BITS;

endmodule

// File: rtl/act_dequant_unpacker.sv
// Unpacks words of LANES packed activations, one lane per clock.
// Each lane is expanded to accumulator fixed point.
// When the final lane of a word is handed off, the next word can be taken in the same cycle,
// so a continuous stream runs at one element per clock.
module act_dequant_unpacker
    import act_pkg::*;
#(
    parameter int DATA_BITWIDTH = act_pkg::DATA_BITWIDTH,
    parameter int ACC_BITWIDTH  = act_pkg::ACC_BITWIDTH,
    parameter int FRAC_BITS     = act_pkg::FRAC_BITS,
    parameter int LANES         = act_pkg::LANES,
    parameter int CNT_WIDTH     = 16,
    localparam int LANE_W       = lane_w(LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DATA_BITWIDTH-1:0] in_data,
    input  logic [LANE_W-1:0]              in_count,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_BITWIDTH-1:0]        out_data,
    output logic                           out_last,
    output logic [CNT_WIDTH-1:0]           elem_cnt
);

    state_t                                state_r, state_nxt_s;
    logic [LANES-1:0][DATA_BITWIDTH-1:0]   word_r, word_nxt_s;
    logic [LANE_W-1:0]                     count_r, count_nxt_s;
    logic [LANE_W-1:0]                     lane_r, lane_nxt_s;
    logic                                  last_r, last_nxt_s;

    logic                                  out_valid_r;
    logic [ACC_BITWIDTH-1:0]               out_data_r, out_data_nxt_s;
    logic                                  out_last_r, out_last_nxt_s;
    logic [CNT_WIDTH-1:0]                  elem_cnt_r, elem_cnt_nxt_s;

    logic                                  final_lane_s;
    logic                                  out_hs_s;
    logic                                  in_hs_s;
    logic                                  in_ready_s;
    logic [DATA_BITWIDTH-1:0]              lane_sel_s;
    logic [ACC_BITWIDTH-1:0]               lane_acc_s;

    assign final_lane_s = (lane_r == count_r);
    assign out_hs_s     = out_valid_r & out_ready;
    assign in_hs_s      = in_valid & in_ready_s;

    // A new word is accepted only when nothing is held, or when the final lane leaves in this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                DRAIN:   in_ready_s = out_ready & final_lane_s;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // Compute the next word, lane and state.
    // When the final lane leaves and a word arrives in the same cycle, the new word is loaded at once.
    always_comb begin
        state_nxt_s = state_r;
        word_nxt_s  = word_r;
        count_nxt_s = count_r;
        lane_nxt_s  = lane_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (in_hs_s) begin
                    word_nxt_s  = in_data;
                    count_nxt_s = in_count;
                    last_nxt_s  = in_last;
                    lane_nxt_s  = {LANE_W{1'b0}};
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAIN: begin
                if (out_hs_s) begin
                    if (!final_lane_s) begin
                        lane_nxt_s = lane_r + LANE_W'(1);
                    end else if (in_hs_s) begin
                        word_nxt_s  = in_data;
                        count_nxt_s = in_count;
                        last_nxt_s  = in_last;
                        lane_nxt_s  = {LANE_W{1'b0}};
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // The frame element count advances on every output handshake.
    // It clears after the handshake of the last element of a frame.
    always_comb begin
        elem_cnt_nxt_s = elem_cnt_r;
        if (out_hs_s) begin
            if (out_last_r) begin
                elem_cnt_nxt_s = {CNT_WIDTH{1'b0}};
            end else begin
                elem_cnt_nxt_s = elem_cnt_r + CNT_WIDTH'(1);
            end
        end else begin
            elem_cnt_nxt_s = elem_cnt_r;
        end
    end

    assign lane_sel_s = word_nxt_s[lane_nxt_s];

    act_dequant #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .ACC_BITWIDTH  (ACC_BITWIDTH),
        .FRAC_BITS     (FRAC_BITS)
    ) u_dequant (
        .lane_data (lane_sel_s),
        .acc_data  (lane_acc_s)
    );

    // Prepare the element that the output registers present next cycle; it is zero while idle.
    always_comb begin
        out_data_nxt_s = {ACC_BITWIDTH{1'b0}};
        out_last_nxt_s = 1'b0;
        if (state_nxt_s == DRAIN) begin
            out_data_nxt_s = lane_acc_s;
            out_last_nxt_s = last_nxt_s & (lane_nxt_s == count_nxt_s);
        end else begin
            out_data_nxt_s = {ACC_BITWIDTH{1'b0}};
            out_last_nxt_s = 1'b0;
        end
    end

    // Register the state, the held word and the outputs.
    // Everything holds under backpressure because no next value changes without a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            word_r      <= '0;
            count_r     <= {LANE_W{1'b0}};
            lane_r      <= {LANE_W{1'b0}};
            last_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_BITWIDTH{1'b0}};
            out_last_r  <= 1'b0;
            elem_cnt_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            word_r      <= word_nxt_s;
            count_r     <= count_nxt_s;
            lane_r      <= lane_nxt_s;
            last_r      <= last_nxt_s;
            out_valid_r <= (state_nxt_s == DRAIN);
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
            elem_cnt_r  <= elem_cnt_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign elem_cnt  = elem_cnt_r;

endmodule
